// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Requester 0 is the CPU, requester 1 the program loader/debug port.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/arb_burst_counter.sv
// Counts granted beats of the current owner; tc flags that the next
// increment completes a MAX_BURST-beat burst.
module arb_burst_counter #(
   parameter int unsigned MAX_BURST = 4,
   localparam int unsigned CNT_W    = $clog2(MAX_BURST + 1)
) (
   input  logic clk,
   input  logic rst_,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == CNT_W'(MAX_BURST - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory between the CPU and
// the loader port, with a bounded burst per ownership.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t state_q, state_d;
   logic       prio_q, prio_d;
   logic       rd_pend0_q, rd_pend0_d;
   logic       rd_pend1_q, rd_pend1_d;
   logic       burst_clr, burst_inc, burst_tc;

   arb_burst_counter #(
      .MAX_BURST (MAX_BURST)
   ) u_burst (
      .clk  (clk),
      .rst_ (rst_),
      .clr  (burst_clr),
      .inc  (burst_inc),
      .tc   (burst_tc)
   );

   always_comb begin
      gnt0      = (state_q == ARB_OWN0) && req0;
      gnt1      = (state_q == ARB_OWN1) && req1;
      state_d   = state_q;
      prio_d    = prio_q;
      burst_clr = 1'b0;
      burst_inc = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            burst_clr = 1'b1;
            if (req0 && req1) begin
               state_d = (prio_q == REQ_LDR) ? ARB_OWN1 : ARB_OWN0;
            end else if (req0) begin
               state_d = ARB_OWN0;
            end else if (req1) begin
               state_d = ARB_OWN1;
            end
         end
         ARB_OWN0: begin
            if (!req0) begin
               prio_d    = REQ_LDR;
               burst_clr = 1'b1;
               state_d   = req1 ? ARB_OWN1 : ARB_IDLE;
            end else begin
               burst_inc = 1'b1;
               if (burst_tc) begin
                  burst_clr = 1'b1;
                  if (req1) begin
                     state_d = ARB_OWN1;
                     prio_d  = REQ_LDR;
                  end
               end
            end
         end
         ARB_OWN1: begin
            if (!req1) begin
               prio_d    = REQ_CPU;
               burst_clr = 1'b1;
               state_d   = req0 ? ARB_OWN0 : ARB_IDLE;
            end else begin
               burst_inc = 1'b1;
               if (burst_tc) begin
                  burst_clr = 1'b1;
                  if (req0) begin
                     state_d = ARB_OWN0;
                     prio_d  = REQ_CPU;
                  end
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_comb begin
      rd_pend0_d = gnt0 && !we0;
      rd_pend1_d = gnt1 && !we1;
      mem_rd     = (gnt0 && !we0) || (gnt1 && !we1);
      mem_wr     = (gnt0 && we0) || (gnt1 && we1);
      // Address/data lines idle on requester 0's values, forced low in reset
      mem_addr   = '0;
      mem_wdata  = '0;
      if (rst_) begin
         mem_addr  = gnt1 ? addr1 : addr0;
         mem_wdata = gnt1 ? wdata1 : wdata0;
      end
      rvalid0 = rd_pend0_q;
      rvalid1 = rd_pend1_q;
      rdata0  = rd_pend0_q ? mem_rdata : '0;
      rdata1  = rd_pend1_q ? mem_rdata : '0;
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q    <= ARB_IDLE;
         prio_q     <= REQ_CPU;
         rd_pend0_q <= 1'b0;
         rd_pend1_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         rd_pend0_q <= rd_pend0_d;
         rd_pend1_q <= rd_pend1_d;
      end
   end

endmodule
